// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit common-anode 7-segment display showing a 128-bit block as four 32-bit pages.
// Optional auto-paging is enabled by defining SEG_SCAN_AUTO_PAGE_EN.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 12500,
  parameter int PAGE_HOLD   = 400
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] data_in,
  input  logic         data_valid,
  input  logic         page_next,
  output logic [3:0]   nibble_out,
  output logic [7:0]   an_n,
  output logic         dp_n,
  output logic [1:0]   page,
  output logic         loaded
);

  localparam int RW = $clog2(REFRESH_DIV);

  if (REFRESH_DIV < 2 || PAGE_HOLD < 1) begin : g_param_check
    $error("seg_scan_ctrl: REFRESH_DIV must be >= 2 and PAGE_HOLD >= 1");
  end

  logic [RW-1:0] refresh_cnt;
  logic [2:0]    digit_idx;
  logic [127:0]  data_reg;
  logic          refresh_tc;
  logic          auto_adv;
  logic          page_adv;

  assign refresh_tc = (refresh_cnt == RW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_tc) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

`ifdef SEG_SCAN_AUTO_PAGE_EN
  localparam int HW = $clog2(PAGE_HOLD + 1);

  logic [HW-1:0] hold_cnt;
  logic          frame_wrap;

  assign frame_wrap = refresh_tc && (digit_idx == 3'd7);
  assign auto_adv   = loaded && frame_wrap && (hold_cnt == HW'(PAGE_HOLD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (data_valid || page_adv) begin
      hold_cnt <= '0;
    end else if (loaded && frame_wrap) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign auto_adv = 1'b0;
`endif

  // A coincident manual and automatic advance still moves the page by one.
  assign page_adv = loaded && (page_next || auto_adv);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg <= '0;
      loaded   <= 1'b0;
      page     <= '0;
    end else if (data_valid) begin
      data_reg <= data_in;
      loaded   <= 1'b1;
      page     <= '0;
    end else if (page_adv) begin
      page     <= page + 2'd1;
    end
  end

  // Nibble index (3-page)*8+digit is simply {~page, digit_idx}.
  always_ff @(posedge clk) begin
    if (!rst_n || !loaded) begin
      an_n       <= '1;
      dp_n       <= 1'b1;
      nibble_out <= '0;
    end else begin
      an_n       <= ~(8'd1 << digit_idx);
      dp_n       <= ({1'b0, page} != digit_idx);
      nibble_out <= data_reg[{~page, digit_idx, 2'b00} +: 4];
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for the board's 8-digit common-anode 7-segment display. It latches a 128-bit AES block (ciphertext, plaintext or key half) and presents it as four pages of eight hex digits. It drives one nibble at a time into the hex-to-7-segment decoder, along with the matching active-low anode and decimal-point lines. It sits between the AES core's result register and the board's display pins.

## Interface
Parameters:
- REFRESH_DIV, 12500: clock cycles each digit is lit. Minimum 2.
- PAGE_HOLD, 400: full 8-digit scan frames per page in auto-page mode. Minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- data_in  in  128  AES block to display.
- data_valid  in  1  one-cycle strobe; latches data_in.
- page_next  in  1  one-cycle strobe (debounced upstream); advances page.
- nibble_out  out  4  hex nibble to the decoder.
- an_n  out  8  digit anodes, active-low, one-hot-low; bit 0 is the rightmost digit.
- dp_n  out  1  decimal point, active-low.
- page  out  2  current page, 0..3.
- loaded  out  1  high once any block has been latched.

## Operation
- Storage: 128-bit data_reg loads on data_valid.
- Page numbering:
  - page 0 shows bits [127:96], page 3 shows bits [31:0].
  - Within a page, digit d (0 = rightmost) shows data_reg[((3-page)*8+d)*4 +: 4].
- Scan sequence:
  - refresh_cnt counts 0..REFRESH_DIV-1.
  - At terminal count, digit_idx advances 0→1→…→7→0.
  - Each wrap 7→0 is one frame.
- Outputs:
  - an_n = ~(1<<digit_idx).
  - nibble_out = selected nibble.
  - dp_n = 0 when digit_idx == page, so the page is marked by the DP position; otherwise 1.
- Blanking: while loaded = 0, an_n = 8'hFF, dp_n = 1, nibble_out = 0. The scan counters still run.
- On data_valid:
  - data_reg <= data_in, loaded <= 1, page <= 0.
  - Frame-hold counter cleared.
  - Scan counters are not disturbed.
- On page_next (loaded = 1 only): page <= page+1, wrapping 3→0, and the hold counter is cleared.
- page_next is ignored while loaded = 0.
- If data_valid and page_next arrive in the same cycle, data_valid wins: page = 0 and page_next is dropped.

## Timing
- All outputs are registered.
- Latency:
  - nibble_out, an_n and dp_n reflect a new digit_idx, page or data_reg one cycle after that state changes.
  - Effect of data_valid at edge N is visible on outputs after edge N+1.
- Each digit is lit for exactly REFRESH_DIV cycles, so a frame is 8*REFRESH_DIV cycles.
- Reset values (rst_n low at an edge):
  - refresh_cnt = 0, digit_idx = 0, page = 0, hold_cnt = 0, loaded = 0, data_reg = 0.
  - an_n = 8'hFF, dp_n = 1, nibble_out = 0.
- Reset mid-scan or mid-page returns to the reset state on the next edge and blanks the display.
- Counter widths: $clog2(REFRESH_DIV) and $clog2(PAGE_HOLD+1). No overflow: counters reset at their terminal count.

## Configuration
- SEG_SCAN_AUTO_PAGE_EN defined:
  - hold_cnt increments on each frame wrap while loaded = 1.
  - When it reaches PAGE_HOLD, page advances (wrapping 3→0) and hold_cnt clears.
  - page_next still works and clears hold_cnt.
  - If an auto-advance and page_next coincide, the page advances by one only.
- Not defined: hold_cnt is not implemented and page changes only via page_next or data_valid.

## Test plan
- Reset, then idle 20 frames with no data_valid → an_n = 8'hFF, dp_n = 1, loaded = 0 throughout; page_next pulses leave page = 0.
- REFRESH_DIV = 4, data_in = 128'h0123456789ABCDEF_FEDCBA9876543210, strobe data_valid → page 0 scans digits 0..7 showing 7,6,5,4,3,2,1,0. Each an_n is low for exactly 4 cycles and dp_n is low only on digit 0.
- Same block, page_next pulsed three times → page 1 shows F..8, page 2 shows 8..F (digit 0 = 8), and page 3 shows 0..7 (digit 0 = 0). The fourth pulse wraps to page 0.
- With page = 2, data_valid and page_next in the same cycle → page = 0 and the new data is shown after one cycle.
- With SEG_SCAN_AUTO_PAGE_EN, REFRESH_DIV = 2, PAGE_HOLD = 3 → page increments every 48 cycles after load and wraps 3→0. A page_next mid-hold restarts the 48-cycle count.
- Assert rst_n low mid-frame while page = 3 → next edge: an_n = 8'hFF, page = 0, loaded = 0, digit_idx = 0.
